single_port_ram: RTL and testbench
==================================

SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, address width; depth SHALL be 2**ADDR_WIDTH (64 words).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 data  input  DATA_WIDTH  write data.
REQ-006 addr  input  ADDR_WIDTH  read/write address; every value 0..63 SHALL be valid, with no out-of-range case.
REQ-007 we  input  1  write enable, sampled at the rising edge.
REQ-008 q  output  DATA_WIDTH  registered read data.
REQ-009 ready  output  1  high when the memory is initialised and accepts accesses.

Function
REQ-010 Storage SHALL be a single array of 2**ADDR_WIDTH words of DATA_WIDTH bits, with one shared port for read and write.
REQ-011 Write: when ready=1 and we=1 at a rising edge, mem[addr] SHALL take data at that edge.
REQ-012 Read: at every rising edge with ready=1, q SHALL load mem[addr]; read latency SHALL be exactly 1 cycle.
REQ-013 Read-during-write SHALL be write-first: when we=1, q SHALL load the new data, not the old contents.
REQ-014 q SHALL change only at a rising edge; no combinational path from addr, data or we to q.
REQ-015 Controller states SHALL be CLEAR and RUN.
REQ-016 In CLEAR, an internal counter SHALL write 0 to mem[cnt] each cycle for cnt = 0..2**ADDR_WIDTH-1.
REQ-017 The CLEAR-to-RUN transition SHALL occur on the edge that writes the last word (cnt = 63); ready SHALL be 1 from the following cycle.
REQ-018 In CLEAR, ready SHALL be 0, we/addr/data SHALL be ignored, and q SHALL be held at 0.
REQ-019 In RUN, ready SHALL be 1 and the block SHALL remain in RUN until reset.
REQ-020 Repeated writes to the same address SHALL each take effect; last write wins.
REQ-021 Address wrap: the clear counter SHALL stop at 63 and SHALL NOT wrap.

Reset
REQ-022 rst=1 at a rising edge SHALL set q=0, ready=0, counter=0 and state=CLEAR.
REQ-023 After rst deasserts, the clear sequence SHALL take exactly 64 cycles before ready=1.
REQ-024 rst asserted mid-clear or in RUN SHALL restart the full clear sequence from address 0.
REQ-025 Memory contents and outputs before the first reset are undefined.

Structure
REQ-026 DATA_WIDTH/ADDR_WIDTH defaults and the state encoding (CLEAR, RUN) SHALL reside in a shared package, single_port_ram_pkg.
REQ-027 The storage array SHALL be one sub-module, spram_core, providing a synchronous write-first read/write port.
REQ-028 The top level SHALL contain the CLEAR/RUN controller and the port mux that selects between the clear counter and the user port.

Verification
REQ-029 Reset then idle: rst high 2 cycles, then low -> ready=0 for 64 cycles, ready=1 on cycle 65, q=0 throughout.
REQ-030 After ready: write addr=5 data=8'hA5, then read addr=5 with we=0 -> q=8'hA5 one cycle after the read edge.
REQ-031 Write-first check: we=1, addr=9, data=8'h3C -> q=8'h3C on the cycle after the write edge.
REQ-032 Boundaries: write addr=0 data=8'h11 and addr=63 data=8'hFF, then read both -> q=8'h11 and 8'hFF respectively; a read of any unwritten address -> q=8'h00.
REQ-033 Write during clear: we=1, addr=3, data=8'h77 while ready=0 -> after ready, a read of addr=3 gives q=8'h00.
REQ-034 Mid-clear reset: rst pulsed at clear cycle 30 -> ready rises exactly 64 cycles after rst deasserts.

Source files
------------

// File: rtl/single_port_ram_pkg.sv
// Shared defaults and controller state encoding for the single-port RAM.
// Imported by the top level and the storage core.
package single_port_ram_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 6;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/spram_core.sv
// Storage array with one synchronous write-first read/write port.
// Read data is registered; rst only clears the output register, not the array.
module spram_core
  import single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write-first: a write forwards its own data to the read register.
  always_comb begin
    rdata_d = '0;
    if (we) begin
      rdata_d = wdata;
    end else begin
      rdata_d = mem[addr];
    end
  end

  // Array write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM top: CLEAR/RUN controller that zero-fills the array after
// reset, and the port mux choosing between the clear counter and the user port.
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};

  state_e                state_d, state_q;
  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;
  logic                  ready_d, ready_q;

  logic                  port_we;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;

  // Next-state logic and port mux. Clearing writes zero, which the
  // write-first core also forwards to q, so q stays 0 throughout CLEAR.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_we    = 1'b0;
    core_addr  = addr;
    core_wdata = data;
    case (state_q)
      CLEAR: begin
        port_we    = 1'b1;
        core_addr  = cnt_q;
        core_wdata = '0;
        if (cnt_q == CNT_MAX) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        port_we = we;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  assign core_we = port_we & ~rst;

  // Controller state, clear counter and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  spram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .we   (core_we),
    .addr (core_addr),
    .wdata(core_wdata),
    .rdata(q)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: directed scenarios plus random
// traffic against a cycle-counting behavioural model of the memory.
module tb_single_port_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [5:0] addr = 6'd0;
  logic       we = 1'b0;
  logic [7:0] q;
  logic       ready;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: memory image, cycles since reset, expected outputs.
  logic [7:0] model_mem [64];
  int         since_rst = 0;
  logic [7:0] exp_q = 8'h00;
  logic       exp_ready = 1'b0;

  single_port_ram dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .addr (addr),
    .we   (we),
    .q    (q),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model, compare both outputs.
  task automatic step(input logic r, input logic w, input logic [5:0] a,
                      input logic [7:0] d, input string tag);
    rst  = r;
    we   = w;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
    if (r) begin
      since_rst = 0;
      exp_q     = 8'h00;
    end else if (since_rst < 64) begin
      model_mem[since_rst] = 8'h00;
      since_rst++;
      exp_q = 8'h00;
    end else begin
      if (w) model_mem[a] = d;
      exp_q = model_mem[a];
    end
    exp_ready = (since_rst >= 64);
    chk({tag, "_q"}, q, exp_q);
    chk({tag, "_ready"}, {7'd0, ready}, {7'd0, exp_ready});
  endtask

  initial begin
    int n;

    // Reset then idle, with a write attempt during clear.
    step(1'b1, 1'b0, 6'd0, 8'h00, "rst0");
    step(1'b1, 1'b0, 6'd0, 8'h00, "rst1");
    for (int i = 0; i < 64; i++) begin
      if (i == 10) step(1'b0, 1'b1, 6'd3, 8'h77, "clr_wr");
      else         step(1'b0, 1'b0, 6'd0, 8'h00, "clr");
    end
    chk("ready_after_64", {7'd0, ready}, 8'h01);

    // Write then read back.
    step(1'b0, 1'b1, 6'd5, 8'hA5, "wr5");
    step(1'b0, 1'b0, 6'd5, 8'h00, "rd5");
    chk("rd5_const", q, 8'hA5);

    // Write-first.
    step(1'b0, 1'b1, 6'd9, 8'h3C, "wf9");
    chk("wf9_const", q, 8'h3C);

    // Address boundaries and unwritten locations.
    step(1'b0, 1'b1, 6'd0, 8'h11, "wr0");
    step(1'b0, 1'b1, 6'd63, 8'hFF, "wr63");
    step(1'b0, 1'b0, 6'd0, 8'h00, "rd0");
    chk("rd0_const", q, 8'h11);
    step(1'b0, 1'b0, 6'd63, 8'h00, "rd63");
    chk("rd63_const", q, 8'hFF);
    step(1'b0, 1'b0, 6'd20, 8'h00, "rd20");
    chk("rd20_const", q, 8'h00);
    step(1'b0, 1'b0, 6'd3, 8'h00, "rd3");
    chk("rd3_clear_write_ignored", q, 8'h00);

    // Repeated writes to one address: last wins.
    step(1'b0, 1'b1, 6'd7, 8'h01, "rep1");
    step(1'b0, 1'b1, 6'd7, 8'h02, "rep2");
    step(1'b0, 1'b0, 6'd7, 8'h00, "rep_rd");
    chk("rep_const", q, 8'h02);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           8'($urandom_range(0, 255)), "rnd");
    end

    // Reset in RUN, then reset again at clear cycle 30 with random inputs.
    step(1'b1, 1'b1, 6'd4, 8'h55, "rst_run");
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           8'($urandom_range(0, 255)), "clr_a");
    end
    step(1'b1, 1'b0, 6'd0, 8'h00, "rst_mid");
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           8'($urandom_range(0, 255)), "clr_b");
      n++;
    end
    chk("mid_rst_latency", 8'(n), 8'd64);

    // Whole array reads back zero after the clear.
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 6'(i), 8'h00, "sweep");
      chk("sweep_zero", q, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
